dct_mac_accum: RTL

//  Accumulate stage directly downstream of the macu mult_res register in each dct_unit.

---
 rtl/dct_mac_accum_if.sv | 24 ++
 rtl/dct_mac_accum.sv | 123 ++++++++++++
 2 files changed

// File: rtl/dct_mac_accum_if.sv
// Product-in / coefficient-out bus of the DCT accumulate stage.
// The producer (macu side) uses the master modport; dct_mac_accum uses slave.
interface dct_mac_accum_if #(
  parameter int MULT_W = 20,
  parameter int OUT_W  = 12
);
  logic              ena;
  logic              dstrb;
  logic              mult_vld;
  logic [MULT_W-1:0] mult_res;
  logic [OUT_W-1:0]  dout;
  logic              dout_vld;
  logic              ovf;

  modport master (
    output ena, dstrb, mult_vld, mult_res,
    input  dout, dout_vld, ovf
  );

  modport slave (
    input  ena, dstrb, mult_vld, mult_res,
    output dout, dout_vld, ovf
  );
endinterface

// File: rtl/dct_mac_accum.sv
// dct_mac_accum: sums TERMS signed products into one DCT coefficient,
// rounds half-up, shifts right by SHIFT and presents the result with a
// one-cycle dout_vld pulse. dstrb restarts the group at any time.
// Optional feature: define DCT_ACC_SAT_EN to clamp out-of-range results to
// the OUT_W signed bounds and raise ovf with that result; otherwise the
// result wraps and ovf stays 0.
module dct_mac_accum #(
  parameter int MULT_W = 20,
  parameter int ACC_W  = 24,
  parameter int TERMS  = 8,
  parameter int SHIFT  = 4,
  parameter int OUT_W  = 12
) (
  input  logic             clk,
  input  logic             rst,   // asynchronous, active-low
  dct_mac_accum_if.slave   bus
);

  localparam int CNT_W = (TERMS > 1) ? $clog2(TERMS) : 1;
  localparam logic [CNT_W-1:0] LAST_TERM = CNT_W'(TERMS - 1);
  localparam logic signed [ACC_W:0] HALF_LSB = (ACC_W+1)'(1) <<< (SHIFT - 1);

  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [OUT_W-1:0]        dout_q, dout_d;
  logic                    vld_q, vld_d;
  logic                    ovf_q, ovf_d;

  logic signed [ACC_W-1:0] ext;
  logic signed [ACC_W-1:0] sum;
  logic signed [ACC_W:0]   rnd_sum;
  logic signed [ACC_W:0]   r;
  logic [OUT_W-1:0]        coef;
  logic                    coef_ovf;

  assign ext = {{(ACC_W-MULT_W){bus.mult_res[MULT_W-1]}}, bus.mult_res};

  // Datapath: running sum including the current product, then round and scale.
  always_comb begin
    sum     = (cnt_q == '0) ? ext : acc_q + ext;
    // One guard bit so adding the rounding constant can never wrap.
    rnd_sum = {sum[ACC_W-1], sum} + HALF_LSB;
    r       = rnd_sum >>> SHIFT;
  end

`ifdef DCT_ACC_SAT_EN
  localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'((2 ** (OUT_W-1)) - 1);
  localparam logic signed [ACC_W:0] SAT_MIN = -((ACC_W+1)'(2 ** (OUT_W-1)));

  // Clamp the scaled result to the signed output range and flag the clamp.
  always_comb begin
    coef     = r[OUT_W-1:0];
    coef_ovf = 1'b0;
    if (r > SAT_MAX) begin
      coef     = SAT_MAX[OUT_W-1:0];
      coef_ovf = 1'b1;
    end else if (r < SAT_MIN) begin
      coef     = SAT_MIN[OUT_W-1:0];
      coef_ovf = 1'b1;
    end
  end
`else
  logic unused_r_msbs;

  // Two's-complement wrap: keep only the low OUT_W bits of the scaled result.
  assign coef          = r[OUT_W-1:0];
  assign coef_ovf      = 1'b0;
  assign unused_r_msbs = ^r[ACC_W:OUT_W];
`endif

  // Next-state: group restart, accumulate, or emit a coefficient on the last term.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    acc_d  = acc_q;
    cnt_d  = cnt_q;
    dout_d = dout_q;
    ovf_d  = ovf_q;
    vld_d  = 1'b0;
    if (bus.ena) begin
      if (bus.dstrb) begin
        // Restart wins over completion; a product this cycle becomes term 0.
        cnt_d = '0;
        if (bus.mult_vld) begin
          acc_d = ext;
          cnt_d = CNT_W'(1);
        end
      end else if (bus.mult_vld) begin
        acc_d = sum;
        if (cnt_q == LAST_TERM) begin
          cnt_d  = '0;
          dout_d = coef;
          ovf_d  = coef_ovf;
          vld_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    end
  end

  // State registers with asynchronous active-low reset that aborts any group.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst) begin
      acc_q  <= '0;
      cnt_q  <= '0;
      dout_q <= '0;
      vld_q  <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      dout_q <= dout_d;
      vld_q  <= vld_d;
      ovf_q  <= ovf_d;
    end
  end

  assign bus.dout     = dout_q;
  assign bus.dout_vld = vld_q;
  assign bus.ovf      = ovf_q;

endmodule
